// File: rtl/cla_pkg.sv
// Shared widths for the 64-bit two-level carry-lookahead adder.
package cla_pkg;
    localparam int CLA_WIDTH = 64;
    localparam int CLA_BLOCK = 4;
    localparam int CLA_NBLK  = CLA_WIDTH / CLA_BLOCK;
endpackage

// File: rtl/cla_4bit.sv
// 4-bit lookahead adder slice; block P/G do not depend on cin.
module cla_4bit
    import cla_pkg::*;
(
    input  logic [CLA_BLOCK-1:0] a,
    input  logic [CLA_BLOCK-1:0] b,
    input  logic                 cin,
    output logic [CLA_BLOCK-1:0] s,
    output logic                 P,
    output logic                 G
);
    logic [CLA_BLOCK-1:0] p, g, c;

    assign p = a ^ b;
    assign g = a & b;

    cla_lookahead4 u_la (
        .p  (p),
        .g  (g),
        .cin(cin),
        .c  (c),
        .P  (P),
        .G  (G)
    );

    assign s = p ^ c;
endmodule

// File: rtl/cla_lookahead4.sv
// Four-way lookahead unit: carries into each of four P/G slices plus group P/G.
module cla_lookahead4
    import cla_pkg::*;
(
    input  logic [CLA_BLOCK-1:0] p,
    input  logic [CLA_BLOCK-1:0] g,
    input  logic                 cin,
    output logic [CLA_BLOCK-1:0] c,
    output logic                 P,
    output logic                 G
);
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign P = &p;
    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/cla_64_bit.sv
// Registered 64-bit adder: 16 x 4-bit slices, 4 group lookaheads, one top lookahead.
module cla_64_bit
    import cla_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [CLA_WIDTH-1:0] s,
    output logic                 P0,
    output logic                 G0,
    output logic                 cout
);
    logic [CLA_NBLK-1:0]  blk_p, blk_g, blk_c;
    logic [CLA_BLOCK-1:0] grp_p, grp_g, grp_c;
    logic                 top_p, top_g;

    logic [CLA_WIDTH-1:0] s_d, s_q;
    logic                 p0_d, p0_q, g0_d, g0_q, cout_d, cout_q;

    for (genvar i = 0; i < CLA_NBLK; i++) begin : g_blk
        cla_4bit u_blk (
            .a  (a[i*CLA_BLOCK +: CLA_BLOCK]),
            .b  (b[i*CLA_BLOCK +: CLA_BLOCK]),
            .cin(blk_c[i]),
            .s  (s_d[i*CLA_BLOCK +: CLA_BLOCK]),
            .P  (blk_p[i]),
            .G  (blk_g[i])
        );
    end

    // Each group's lookahead takes its carry-in from the top-level unit.
    for (genvar j = 0; j < CLA_BLOCK; j++) begin : g_grp
        cla_lookahead4 u_grp (
            .p  (blk_p[j*CLA_BLOCK +: CLA_BLOCK]),
            .g  (blk_g[j*CLA_BLOCK +: CLA_BLOCK]),
            .cin(grp_c[j]),
            .c  (blk_c[j*CLA_BLOCK +: CLA_BLOCK]),
            .P  (grp_p[j]),
            .G  (grp_g[j])
        );
    end

    cla_lookahead4 u_top (
        .p  (grp_p),
        .g  (grp_g),
        .cin(cin),
        .c  (grp_c),
        .P  (top_p),
        .G  (top_g)
    );

    assign p0_d   = top_p;
    assign g0_d   = top_g;
    assign cout_d = top_g | (top_p & cin);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            p0_q   <= 1'b0;
            g0_q   <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            p0_q   <= p0_d;
            g0_q   <= g0_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign P0   = p0_q;
    assign G0   = g0_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_cla_64_bit.sv
// Directed and random checks of cla_64_bit against a plain-arithmetic reference.
module tb_cla_64_bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic [63:0] s;
    logic        P0, G0, cout;

    int vectors = 0;
    int miscompares = 0;

    cla_64_bit dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .cin (cin),
        .s   (s),
        .P0  (P0),
        .G0  (G0),
        .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one vector at the falling edge, then check outputs just after the next rising edge.
    task automatic step(input logic r, input logic [63:0] va, input logic [63:0] vb, input logic vc);
        logic [64:0] full, nocin;
        logic [63:0] es;
        logic        ec, ep, eg;
        @(negedge clk);
        rst = r; a = va; b = vb; cin = vc;
        full  = {1'b0, va} + {1'b0, vb} + {64'd0, vc};
        nocin = {1'b0, va} + {1'b0, vb};
        if (r) begin
            es = '0; ec = 1'b0; ep = 1'b0; eg = 1'b0;
        end else begin
            es = full[63:0];
            ec = full[64];
            ep = ((va ^ vb) == {64{1'b1}});
            eg = nocin[64];
        end
        @(posedge clk);
        #1;
        vectors++;
        chk("s",    s,                es);
        chk("cout", {63'd0, cout},    {63'd0, ec});
        chk("P0",   {63'd0, P0},      {63'd0, ep});
        chk("G0",   {63'd0, G0},      {63'd0, eg});
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic        rc;
        // Reset overrides the inputs presented at the same edge.
        step(1'b1, 64'd5, 64'd12, 1'b0);
        step(1'b0, 64'd0, 64'd0, 1'b0);
        step(1'b0, 64'd5, 64'd12, 1'b0);
        step(1'b0, 64'd5, 64'd12, 1'b0);
        step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        step(1'b0, 64'h0000_FFFF_0000_FFFF, 64'd1, 1'b0);
        step(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        step(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1);
        step(1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
        step(1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);

        // Back-to-back random traffic with reset pulsed mid-stream.
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(0, 1));
            // Occasionally force long propagate runs across group boundaries.
            if (i % 7 == 3) rb = ~ra;
            if (i % 11 == 5) rb = ~ra ^ (64'd1 << $urandom_range(0, 63));
            step((i == 60) || (i == 61) || (i == 150), ra, rb, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
